// File: rtl/fpu_arb_pkg.sv
// Shared types for the fpu_add arbiter: data width, requester tag, in-flight entry.
package fpu_arb_pkg;

  localparam int FP_W  = 32;
  localparam int TAG_W = 3;   // wide enough for up to 8 requesters

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } entry_t;

  // Round-robin pointer step: index after cur, wrapping at n.
  function automatic tag_t next_ptr(input tag_t cur, input int n);
    return (int'(cur) >= n - 1) ? tag_t'(0) : tag_t'(cur + tag_t'(1));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest requesting index at or above ptr, wrapping.
// Produces nothing when advance is low.
module rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  tag_t         ptr,
  input  logic         advance,
  output logic [N-1:0] grant,
  output tag_t         idx,
  output logic         any
);

  logic hit_s;

  // Scan candidates in priority order ptr, ptr+1, ...; first active one wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        hit_s    = advance && !any && req[j] && (j == ((int'(ptr) + k) % N));
        grant[j] = grant[j] | hit_s;
        idx      = hit_s ? TAG_W'(j) : idx;
        any      = any | hit_s;
      end
    end
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one pipelined fpu_add among N_REQ requesters. A registered issue stage
// feeds the FPU; a tag pipe of LATENCY stages tracks in-flight ops so the tail
// stage lines up with fpu_z. A held response at the tail freezes everything.
// Optional: FPU_ARB_STATS_EN adds saturating issue/stall counters.
module fpu_add_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*FP_W-1:0]   req_a,
  input  logic [N_REQ*FP_W-1:0]   req_b,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [FP_W-1:0]         resp_z,
  output logic                    fpu_en,
  output logic [FP_W-1:0]         fpu_a,
  output logic [FP_W-1:0]         fpu_b,
  input  logic [FP_W-1:0]         fpu_z
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]  stat_issue_cnt,
  output logic [CNT_W-1:0]        stat_stall_cnt
`endif
);

  entry_t            iss_r;
  entry_t            pipe_r [LATENCY];
  logic [FP_W-1:0]   a_r;
  logic [FP_W-1:0]   b_r;
  tag_t              ptr_r;

  entry_t            tail_s;
  logic              tail_ready_s;
  logic              advance_s;
  logic [N_REQ-1:0]  grant_s;
  tag_t              gidx_s;
  logic              any_s;
  logic [FP_W-1:0]   sel_a_s;
  logic [FP_W-1:0]   sel_b_s;

  assign tail_s = pipe_r[LATENCY-1];

  // Steer the tail result to its owner and look up that owner's ready
  always_comb begin
    tail_ready_s = 1'b0;
    resp_valid   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      resp_valid[j] = tail_s.valid && (tail_s.tag == TAG_W'(j)) && !RESET;
      tail_ready_s  = tail_ready_s | ((tail_s.tag == TAG_W'(j)) && resp_ready[j]);
    end
  end

  assign fpu_en    = !(tail_s.valid && !tail_ready_s);
  assign advance_s = fpu_en;
  assign resp_z    = fpu_z;
  assign fpu_a     = a_r;
  assign fpu_b     = b_r;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_r),
    .advance (advance_s && !RESET),
    .grant   (grant_s),
    .idx     (gidx_s),
    .any     (any_s)
  );

  assign req_ready = grant_s;

  // Select the granted requester's operand pair (grant is one-hot or zero)
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int j = 0; j < N_REQ; j++) begin
      sel_a_s = sel_a_s | ({FP_W{grant_s[j]}} & req_a[j*FP_W +: FP_W]);
      sel_b_s = sel_b_s | ({FP_W{grant_s[j]}} & req_b[j*FP_W +: FP_W]);
    end
  end

  // Issue register, tag pipe and RR pointer; all hold while the FPU is frozen
  always_ff @(posedge CLK) begin
    if (RESET) begin
      iss_r <= '0;
      a_r   <= '0;
      b_r   <= '0;
      ptr_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_r[i] <= '0;
      end
    end else if (advance_s) begin
      iss_r.valid <= any_s;
      iss_r.tag   <= gidx_s;
      if (any_s) begin
        a_r   <= sel_a_s;
        b_r   <= sel_b_s;
        ptr_r <= next_ptr(gidx_s, N_REQ);
      end
      pipe_r[0] <= iss_r;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

`ifdef FPU_ARB_STATS_EN
  logic [CNT_W-1:0] issue_cnt_r [N_REQ];
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating per-requester accept counters and frozen-cycle counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_r <= '0;
      for (int j = 0; j < N_REQ; j++) begin
        issue_cnt_r[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_REQ; j++) begin
        if (grant_s[j] && (issue_cnt_r[j] != {CNT_W{1'b1}})) begin
          issue_cnt_r[j] <= issue_cnt_r[j] + CNT_W'(1);
        end
      end
      if (!fpu_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  // Flatten the counter array onto the output bus
  always_comb begin
    stat_issue_cnt = '0;
    for (int j = 0; j < N_REQ; j++) begin
      stat_issue_cnt[j*CNT_W +: CNT_W] = issue_cnt_r[j];
    end
  end

  assign stat_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: a behavioural fpu_add (real arithmetic, 3-cycle
// pipe gated by EN), per-requester operand queues, and a scoreboard that predicts
// grants, response timing/tag/value and stalls from the arbitration rules.
module tb_fpu_add_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int CW  = 16;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0]   req_a, req_b;
  logic [31:0]       resp_z, fpu_a, fpu_b, fpu_z;
  logic              fpu_en;
`ifdef FPU_ARB_STATS_EN
  logic [N*CW-1:0]   stat_issue_cnt;
  logic [CW-1:0]     stat_stall_cnt;
`endif

  fpu_add_arbiter #(.N_REQ(N), .LATENCY(LAT), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
    .fpu_en(fpu_en), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_z(fpu_z)
`ifdef FPU_ARB_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // IEEE single <-> real, normal numbers and zero only
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  // Behavioural fpu_add: three stages, frozen when EN is low
  logic [31:0] fz_p [3];
  always @(posedge CLK) begin
    if (fpu_en) begin
      fz_p[0] <= r2sp(sp2r(fpu_a) + sp2r(fpu_b));
      fz_p[1] <= fz_p[0];
      fz_p[2] <= fz_p[1];
    end
  end
  assign fpu_z = fz_p[2];

  typedef struct { int tag; logic [31:0] z; int due; } sb_t;

  logic [63:0] pend [N][$];
  sb_t         sb [$];
  int          grant_log [$];
  int          ptr_m, cyc, n_checks, n_err;
  int          bp_arm, bp_left, bp_len, rand_ready, obs_stalls;
  int          last_resp_cyc, last_grant_cyc, resp_seen, stalls_m;
  int          issued_m [N];
  logic [31:0] last_resp_z;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [63:0] op;
    if (bp_arm != 0 && sb.size() > 0 && sb[0].tag == 1 && sb[0].due == cyc) begin
      bp_arm  = 0;
      bp_left = bp_len;
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pend[i].size() > 0);
      op = (pend[i].size() > 0) ? pend[i][0] : 64'd0;
      req_a[i*32 +: 32] = op[63:32];
      req_b[i*32 +: 32] = op[31:0];
      resp_ready[i] = (rand_ready != 0) ? ($urandom_range(9) != 0) : 1'b1;
    end
    if (bp_left > 0) resp_ready[1] = 1'b0;
  endtask

  // One clock: drive, check at negedge against the model, then advance the model
  task automatic tick();
    logic [N-1:0] exp_rv, exp_rr;
    logic         exp_en;
    int           g, c;
    logic [63:0]  op;
    sb_t          e;
    drive_inputs();
    @(negedge CLK);
    exp_rv = '0; exp_rr = '0; exp_en = 1'b1; g = -1;
    if (RESET == 1'b0) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_rv[sb[0].tag] = 1'b1;
        exp_en = resp_ready[sb[0].tag];
      end
      if (exp_en) begin
        for (int k = 0; k < N; k++) begin
          c = (ptr_m + k) % N;
          if (g < 0 && pend[c].size() > 0) g = c;
        end
      end
      if (g >= 0) exp_rr[g] = 1'b1;
      chk("fpu_en", fpu_en, exp_en);
    end
    chk("req_ready", req_ready, exp_rr);
    chk("resp_valid", resp_valid, exp_rv);
    if (exp_rv != 0) chk("resp_z", resp_z, sb[0].z);
    // observed activity for directed checks
    if (!fpu_en && !RESET) obs_stalls++;
    if ((resp_valid & resp_ready) != 0) begin
      last_resp_cyc = cyc; last_resp_z = resp_z; resp_seen++;
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    // model update
    if (RESET) begin
      sb.delete(); ptr_m = 0; stalls_m = 0;
      for (int i = 0; i < N; i++) issued_m[i] = 0;
    end else begin
      if (!exp_en) begin
        stalls_m++;
        for (int i = 0; i < sb.size(); i++) sb[i].due++;
      end else if (exp_rv != 0) begin
        void'(sb.pop_front());
      end
      if (g >= 0) begin
        op = pend[g].pop_front();
        e.tag = g;
        e.z   = r2sp(sp2r(op[63:32]) + sp2r(op[31:0]));
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        ptr_m = (g + 1) % N;
        issued_m[g]++;
        last_grant_cyc = cyc;
      end
    end
    if (bp_left > 0) bp_left--;
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int budget);
    int left, n;
    left = budget;
    n = sb.size() + pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size();
    while (n != 0 && left > 0) begin
      tick();
      left--;
      n = sb.size() + pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size();
    end
    chk("drain_left", n, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  function automatic logic [63:0] rnd_op();
    return {r2sp(real'($urandom_range(65535, 1))), r2sp(real'($urandom_range(65535, 1)))};
  endfunction

  int t0, exp_g [$];

  initial begin
    n_checks = 0; n_err = 0; cyc = 0; ptr_m = 0; bp_arm = 0; bp_left = 0; bp_len = 5;
    rand_ready = 0; obs_stalls = 0; resp_seen = 0; stalls_m = 0;
    last_resp_cyc = 0; last_grant_cyc = 0; last_resp_z = 32'd0;
    for (int i = 0; i < N; i++) issued_m[i] = 0;
    RESET = 1'b1;
    tick();
    do_reset();

    // reset state
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);

    // single op: 1.5 + 2.25 = 3.75, four cycles after accept
    pend[0].push_back({32'h3FC00000, 32'h40100000});
    tick();
    t0 = last_grant_cyc;
    drain(30);
    chk("single_lat", last_resp_cyc - t0, 4);
    chk("single_z", last_resp_z, 32'h40700000);

    // round robin with all four requesters busy
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      pend[i].push_back(rnd_op());
      pend[i].push_back(rnd_op());
    end
    t0 = cyc;
    drain(60);
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], exp_g[i]);
    chk("rr_nobubble", last_grant_cyc - t0, 7);

    // backpressure: requester 1 holds its result for five cycles
    obs_stalls = 0; resp_seen = 0;
    for (int i = 0; i < N; i++) pend[i].push_back(rnd_op());
    bp_arm = 1;
    drain(60);
    chk("bp_stalls", obs_stalls, 5);
    chk("bp_resps", resp_seen, 4);

    // skip idle requesters, then wrap 3 -> 0
    do_reset();
    grant_log.delete();
    pend[2].push_back(rnd_op()); pend[2].push_back(rnd_op());
    pend[3].push_back(rnd_op()); pend[3].push_back(rnd_op());
    drain(40);
    exp_g = '{2, 3, 2, 3};
    chk("skip_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("skip_order", grant_log[i], exp_g[i]);
    grant_log.delete();
    pend[1].push_back(rnd_op()); pend[0].push_back(rnd_op());
    drain(40);
    chk("wrap_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // reset with three ops in flight
    pend[2].push_back(rnd_op()); pend[3].push_back(rnd_op()); pend[1].push_back(rnd_op());
    tick(); tick(); tick(); tick();
    do_reset();
    resp_seen = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("rst_noresp", resp_seen, 0);
    grant_log.delete();
    pend[3].push_back(rnd_op()); pend[0].push_back(rnd_op());
    drain(40);
    chk("rst_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // randomized traffic with random response backpressure
    rand_ready = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (pend[i].size() < 2 && $urandom_range(2) == 0) pend[i].push_back(rnd_op());
      tick();
    end
    rand_ready = 0;
    drain(200);

`ifdef FPU_ARB_STATS_EN
    // statistics: 10 ops from requester 1, three stall cycles
    do_reset();
    bp_len = 3;
    for (int i = 0; i < 10; i++) pend[1].push_back(rnd_op());
    bp_arm = 1;
    drain(80);
    chk("stat_issue1", stat_issue_cnt[1*CW +: CW], 16'd10);
    chk("stat_stall", stat_stall_cnt, 16'd3);
    chk("stat_issue0", stat_issue_cnt[0 +: CW], issued_m[0]);
    chk("stat_stall_m", stat_stall_cnt, stalls_m);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
